// File: rtl/axist_dual_pkg.sv
// Shared constants and pattern helpers for the dual-direction AXI4-Stream link test.
package axist_dual_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned DATA_W = LANES * LANE_W;

    localparam logic [15:0] ADDR_PAGE  = 16'h5000;
    localparam logic [15:0] A_L2F_CTRL = 16'h1000;
    localparam logic [15:0] A_L2F_STAT = 16'h1004;
    localparam logic [15:0] A_F2L_CTRL = 16'h1008;
    localparam logic [15:0] A_F2L_STAT = 16'h100C;
    localparam logic [15:0] A_LINKUP   = 16'h1010;
    localparam logic [15:0] A_DLY_X    = 16'h2000;
    localparam logic [15:0] A_DLY_Y    = 16'h2004;
    localparam logic [15:0] A_DLY_Z    = 16'h2008;
    localparam logic [15:0] A_SOFT_RST = 16'h3000;

    localparam logic [31:0] DLY_X_RST = 32'd12;
    localparam logic [31:0] DLY_Y_RST = 32'd32;
    localparam logic [31:0] DLY_Z_RST = 32'd6000;

    // Fibonacci taps 32,22,2,1 as a bit mask over s[31:0]
    localparam logic [LANE_W-1:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [LANE_W-1:0] SEED_L2F  = 32'hA5A5_0000;
    localparam logic [LANE_W-1:0] SEED_F2L  = 32'h5A5A_0000;

    localparam int unsigned ST_OK      = 0;
    localparam int unsigned ST_ALIGNED = 1;
    localparam int unsigned ST_DONE    = 3;

    function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] s);
        return {s[LANE_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [DATA_W-1:0] first_beat(input logic [LANE_W-1:0] seed,
                                                      input logic lfsr);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < LANES; k++)
            d[k*LANE_W +: LANE_W] = lfsr ? seed + LANE_W'(k) : LANE_W'(k);
        return d;
    endfunction

    // Counter lanes advance by LANES so lane k always holds count*LANES+k
    function automatic logic [DATA_W-1:0] next_beat(input logic [DATA_W-1:0] cur,
                                                     input logic lfsr);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < LANES; k++)
            d[k*LANE_W +: LANE_W] = lfsr ? lfsr_step(cur[k*LANE_W +: LANE_W])
                                         : cur[k*LANE_W +: LANE_W] + LANE_W'(LANES);
        return d;
    endfunction

endpackage

// File: rtl/axist_dual_link_test_dir.sv
// One stream direction: pattern generator, fixed-latency link pipe, checker and beat capture.
module axist_dir_test
    import axist_dual_pkg::*;
#(
    parameter int unsigned       LINK_LAT = 4,
    parameter logic [LANE_W-1:0] SEED     = SEED_L2F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst,
    input  logic              start,
    input  logic              start_lfsr,
    input  logic [7:0]        start_last,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              idle,
    output logic [3:0]        status,
    output logic [DATA_W-1:0] cap_tx_first,
    output logic [DATA_W-1:0] cap_tx_last,
    output logic [DATA_W-1:0] cap_rx_first,
    output logic [DATA_W-1:0] cap_rx_last
);

    logic                             mode_lfsr;
    logic [7:0]                       last_idx;
    logic                             tx_busy;
    logic [7:0]                       tx_cnt;
    logic [DATA_W-1:0]                gen_data;
    logic [LINK_LAT-1:0]              pipe_vld;
    logic [LINK_LAT-1:0][DATA_W-1:0]  pipe_data;
    logic                             rx_valid;
    logic [DATA_W-1:0]                rx_data;
    logic                             rx_busy;
    logic [7:0]                       rx_cnt;
    logic [DATA_W-1:0]                exp_data;
    logic                             st_ok;
    logic                             st_aligned;
    logic                             st_done;
    logic                             tx_xfer;
    logic                             rx_take;

    assign tx_xfer  = tx_busy & tx_ready;
    assign rx_valid = pipe_vld[LINK_LAT-1];
    assign rx_data  = pipe_data[LINK_LAT-1];
    assign rx_take  = rx_valid & rx_busy;

    assign tx_data  = gen_data;
    assign tx_valid = tx_busy;
    assign idle     = ~tx_busy & ~rx_busy;
    assign status   = {st_done, 1'b0, st_aligned, st_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_lfsr  <= 1'b0;
            last_idx   <= '0;
            tx_busy    <= 1'b0;
            tx_cnt     <= '0;
            gen_data   <= '0;
            pipe_vld   <= '0;
            pipe_data  <= '0;
            rx_busy    <= 1'b0;
            rx_cnt     <= '0;
            exp_data   <= '0;
            st_ok      <= 1'b0;
            st_aligned <= 1'b0;
            st_done    <= 1'b0;
        end else if (soft_rst) begin
            tx_busy    <= 1'b0;
            tx_cnt     <= '0;
            gen_data   <= '0;
            pipe_vld   <= '0;
            pipe_data  <= '0;
            rx_busy    <= 1'b0;
            rx_cnt     <= '0;
            exp_data   <= '0;
            st_ok      <= 1'b0;
            st_aligned <= 1'b0;
            st_done    <= 1'b0;
        end else begin
            pipe_vld[0]  <= tx_xfer;
            pipe_data[0] <= gen_data;
            for (int unsigned i = 1; i < LINK_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            if (start) begin
                mode_lfsr  <= start_lfsr;
                last_idx   <= start_last;
                tx_busy    <= 1'b1;
                tx_cnt     <= '0;
                gen_data   <= first_beat(SEED, start_lfsr);
                rx_busy    <= 1'b1;
                rx_cnt     <= '0;
                exp_data   <= first_beat(SEED, start_lfsr);
                st_ok      <= 1'b1;
                st_aligned <= 1'b0;
                st_done    <= 1'b0;
            end else begin
                if (tx_xfer) begin
                    gen_data <= next_beat(gen_data, mode_lfsr);
                    tx_cnt   <= tx_cnt + 8'd1;
                    if (tx_cnt == last_idx)
                        tx_busy <= 1'b0;
                end
                if (rx_take) begin
                    if (rx_data != exp_data)
                        st_ok <= 1'b0;
                    st_aligned <= 1'b1;
                    exp_data   <= next_beat(exp_data, mode_lfsr);
                    rx_cnt     <= rx_cnt + 8'd1;
                    if (rx_cnt == last_idx) begin
                        rx_busy <= 1'b0;
                        st_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Captures survive soft reset so a failed run can still be inspected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_tx_first <= '0;
            cap_tx_last  <= '0;
            cap_rx_first <= '0;
            cap_rx_last  <= '0;
        end else if (!soft_rst) begin
            if (tx_xfer && tx_cnt == 8'd0)     cap_tx_first <= gen_data;
            if (tx_xfer && tx_cnt == last_idx) cap_tx_last  <= gen_data;
            if (rx_take && rx_cnt == 8'd0)     cap_rx_first <= rx_data;
            if (rx_take && rx_cnt == last_idx) cap_rx_last  <= rx_data;
        end
    end

endmodule

// File: rtl/axist_dual_link_test.sv
// Register-controlled L2F/F2L AXI4-Stream link test top with link-up timer and capture readback.
module axist_dual_link_test
    import axist_dual_pkg::*;
#(
    parameter int unsigned LINK_LAT = 4,
    parameter int unsigned PAT_W    = 256
) (
    input  logic               ms_wr_clk,
    input  logic               i_w_m_wr_rst_n,
    input  logic [31:0]        i_wr_addr,
    input  logic [31:0]        i_wrdata,
    input  logic               i_wren,
    input  logic               i_rden,
    output logic [31:0]        o_master_readdata,
    output logic               o_master_readdatavalid,
    output logic               o_master_waitreq,
    output logic [PAT_W-1:0]   o_tb_patdout,
    output logic               o_tb_axist_valid,
    output logic               o_tb_axist_ready,
    output logic [2*PAT_W-1:0] o_tb_f2l_patdout,
    output logic               o_tb_f2l_axist_valid,
    output logic               o_tb_f2l_axist_ready,
    output logic               tx_online,
    output logic               rx_online,
    output logic               test_done
);

    logic [31:0]       dly_x, dly_y, dly_z;
    logic              soft_rst;
    logic [31:0]       l2f_ctrl, f2l_ctrl;
    logic [31:0]       linkup_cnt;
    logic              linkup;
    logic              rden_d;
    logic              page_hit;
    logic [15:0]       off;
    logic              l2f_idle, f2l_idle;
    logic              l2f_start_c, f2l_start_c;
    logic [3:0]        l2f_status, f2l_status;
    logic [DATA_W-1:0] l2f_tx_data, f2l_tx_data;
    logic [DATA_W-1:0] l2f_cap [4];
    logic [DATA_W-1:0] f2l_cap [4];
    logic [DATA_W-1:0] cap_blk_c;
    logic [31:0]       rd_mux_c;

    assign page_hit    = (i_wr_addr[31:16] == ADDR_PAGE);
    assign off         = i_wr_addr[15:0];
    assign l2f_start_c = i_wren & page_hit & (off == A_L2F_CTRL) & i_wrdata[0] & l2f_idle & ~soft_rst;
    assign f2l_start_c = i_wren & page_hit & (off == A_F2L_CTRL) & i_wrdata[0] & f2l_idle & ~soft_rst;

    assign o_master_waitreq     = 1'b0;
    assign o_tb_patdout         = l2f_tx_data;
    assign o_tb_axist_ready     = linkup;
    assign o_tb_f2l_patdout     = {{PAT_W{1'b0}}, f2l_tx_data};
    assign o_tb_f2l_axist_ready = linkup;

    axist_dir_test #(.LINK_LAT(LINK_LAT), .SEED(SEED_L2F)) u_l2f (
        .clk          (ms_wr_clk),
        .rst_n        (i_w_m_wr_rst_n),
        .soft_rst     (soft_rst),
        .start        (l2f_start_c),
        .start_lfsr   (i_wrdata[2:1] == 2'b10),
        .start_last   (i_wrdata[11:4]),
        .tx_ready     (linkup),
        .tx_data      (l2f_tx_data),
        .tx_valid     (o_tb_axist_valid),
        .idle         (l2f_idle),
        .status       (l2f_status),
        .cap_tx_first (l2f_cap[0]),
        .cap_tx_last  (l2f_cap[1]),
        .cap_rx_first (l2f_cap[2]),
        .cap_rx_last  (l2f_cap[3])
    );

    axist_dir_test #(.LINK_LAT(LINK_LAT), .SEED(SEED_F2L)) u_f2l (
        .clk          (ms_wr_clk),
        .rst_n        (i_w_m_wr_rst_n),
        .soft_rst     (soft_rst),
        .start        (f2l_start_c),
        .start_lfsr   (i_wrdata[2:1] == 2'b10),
        .start_last   (i_wrdata[11:4]),
        .tx_ready     (linkup),
        .tx_data      (f2l_tx_data),
        .tx_valid     (o_tb_f2l_axist_valid),
        .idle         (f2l_idle),
        .status       (f2l_status),
        .cap_tx_first (f2l_cap[0]),
        .cap_tx_last  (f2l_cap[1]),
        .cap_rx_first (f2l_cap[2]),
        .cap_rx_last  (f2l_cap[3])
    );

    // Register writes; control words only latch while that direction is idle
    always_ff @(posedge ms_wr_clk or negedge i_w_m_wr_rst_n) begin
        if (!i_w_m_wr_rst_n) begin
            dly_x    <= DLY_X_RST;
            dly_y    <= DLY_Y_RST;
            dly_z    <= DLY_Z_RST;
            soft_rst <= 1'b0;
            l2f_ctrl <= '0;
            f2l_ctrl <= '0;
        end else if (i_wren && page_hit) begin
            case (off)
                A_DLY_X:    dly_x    <= i_wrdata;
                A_DLY_Y:    dly_y    <= i_wrdata;
                A_DLY_Z:    dly_z    <= i_wrdata;
                A_SOFT_RST: soft_rst <= i_wrdata[0];
                A_L2F_CTRL: if (l2f_idle) l2f_ctrl <= i_wrdata;
                A_F2L_CTRL: if (f2l_idle) f2l_ctrl <= i_wrdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ms_wr_clk or negedge i_w_m_wr_rst_n) begin
        if (!i_w_m_wr_rst_n) begin
            linkup_cnt <= '0;
            linkup     <= 1'b0;
            tx_online  <= 1'b0;
            rx_online  <= 1'b0;
            test_done  <= 1'b0;
        end else begin
            if (soft_rst) begin
                linkup_cnt <= '0;
                linkup     <= 1'b0;
            end else if (linkup_cnt >= dly_x) begin
                linkup <= 1'b1;
            end else begin
                linkup_cnt <= linkup_cnt + 32'd1;
            end
            tx_online <= linkup;
            rx_online <= linkup;
            test_done <= l2f_status[ST_DONE] & f2l_status[ST_DONE];
        end
    end

    // Capture window: 0x4X00/0x5X00 + 4*word, X selects first/last TX/RX
    always_comb begin
        cap_blk_c = '0;
        rd_mux_c  = '0;
        if (off[12]) cap_blk_c = f2l_cap[off[9:8]];
        else         cap_blk_c = l2f_cap[off[9:8]];
        if (page_hit) begin
            case (off)
                A_L2F_CTRL: rd_mux_c = l2f_ctrl;
                A_L2F_STAT: rd_mux_c = {28'd0, l2f_status};
                A_F2L_CTRL: rd_mux_c = f2l_ctrl;
                A_F2L_STAT: rd_mux_c = {28'd0, f2l_status};
                A_LINKUP:   rd_mux_c = {28'd0, {4{linkup}}};
                A_DLY_X:    rd_mux_c = dly_x;
                A_DLY_Y:    rd_mux_c = dly_y;
                A_DLY_Z:    rd_mux_c = dly_z;
                A_SOFT_RST: rd_mux_c = {31'd0, soft_rst};
                default:
                    if (off[15:13] == 3'b010 && off[11:10] == 2'b00 &&
                        off[7:5] == 3'b000 && off[1:0] == 2'b00)
                        rd_mux_c = cap_blk_c[{off[4:2], 5'd0} +: 32];
            endcase
        end
    end

    // One response per rising edge of the read strobe
    always_ff @(posedge ms_wr_clk or negedge i_w_m_wr_rst_n) begin
        if (!i_w_m_wr_rst_n) begin
            rden_d                 <= 1'b0;
            o_master_readdatavalid <= 1'b0;
            o_master_readdata      <= '0;
        end else begin
            rden_d                 <= i_rden;
            o_master_readdatavalid <= i_rden & ~rden_d;
            if (i_rden && !rden_d)
                o_master_readdata <= rd_mux_c;
        end
    end

endmodule

// File: tb/tb_axist_dual_link_test.sv
// Scoreboard bench: register reads push expected data, a monitor checks each read response.
module tb_axist_dual_link_test;

    logic         ms_wr_clk = 1'b0;
    logic         i_w_m_wr_rst_n;
    logic [31:0]  i_wr_addr;
    logic [31:0]  i_wrdata;
    logic         i_wren;
    logic         i_rden;
    logic [31:0]  o_master_readdata;
    logic         o_master_readdatavalid;
    logic         o_master_waitreq;
    logic [255:0] o_tb_patdout;
    logic         o_tb_axist_valid;
    logic         o_tb_axist_ready;
    logic [511:0] o_tb_f2l_patdout;
    logic         o_tb_f2l_axist_valid;
    logic         o_tb_f2l_axist_ready;
    logic         tx_online;
    logic         rx_online;
    logic         test_done;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          resp_cnt = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] l2f_first[8], l2f_last[8], f2l_first[8], f2l_last[8];
    logic [255:0] corrupt;

    always #5 ms_wr_clk = ~ms_wr_clk;

    axist_dual_link_test #(.LINK_LAT(4), .PAT_W(256)) dut (
        .ms_wr_clk              (ms_wr_clk),
        .i_w_m_wr_rst_n         (i_w_m_wr_rst_n),
        .i_wr_addr              (i_wr_addr),
        .i_wrdata               (i_wrdata),
        .i_wren                 (i_wren),
        .i_rden                 (i_rden),
        .o_master_readdata      (o_master_readdata),
        .o_master_readdatavalid (o_master_readdatavalid),
        .o_master_waitreq       (o_master_waitreq),
        .o_tb_patdout           (o_tb_patdout),
        .o_tb_axist_valid       (o_tb_axist_valid),
        .o_tb_axist_ready       (o_tb_axist_ready),
        .o_tb_f2l_patdout       (o_tb_f2l_patdout),
        .o_tb_f2l_axist_valid   (o_tb_f2l_axist_valid),
        .o_tb_f2l_axist_ready   (o_tb_f2l_axist_ready),
        .tx_online              (tx_online),
        .rx_online              (rx_online),
        .test_done              (test_done)
    );

    function automatic logic [31:0] m_lfsr(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every read response is matched against the oldest expectation
    always @(negedge ms_wr_clk) begin
        if (i_w_m_wr_rst_n && o_master_readdatavalid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_resp: got 0x%08h expected no response", o_master_readdata);
            end else begin
                check(name_q.pop_front(), o_master_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge ms_wr_clk); #1;
        i_wr_addr = a; i_wrdata = d; i_wren = 1'b1;
        @(posedge ms_wr_clk); #1;
        i_wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge ms_wr_clk); #1;
        i_wr_addr = a; i_rden = 1'b1;
        @(posedge ms_wr_clk); #1;
        i_rden = 1'b0;
        @(posedge ms_wr_clk); #1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i;
        i = 0;
        while (!test_done && i < budget) begin
            @(posedge ms_wr_clk); #1;
            i++;
        end
        check(nm, 32'(test_done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [31:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 32'hA5A5_0000 + 32'(k);
            l2f_first[k] = v;
            repeat (255) v = m_lfsr(v);
            l2f_last[k] = v;
            v = 32'h5A5A_0000 + 32'(k);
            f2l_first[k] = v;
            repeat (255) v = m_lfsr(v);
            f2l_last[k] = v;
        end

        i_w_m_wr_rst_n = 1'b0;
        i_wr_addr = '0; i_wrdata = '0; i_wren = 1'b0; i_rden = 1'b0;
        repeat (3) @(posedge ms_wr_clk);
        #1;
        check("rst_rdvalid", 32'(o_master_readdatavalid), 32'd0);
        check("rst_rddata", o_master_readdata, 32'd0);
        check("rst_l2f_valid", 32'(o_tb_axist_valid), 32'd0);
        check("rst_test_done", 32'(test_done), 32'd0);
        check("rst_waitreq", 32'(o_master_waitreq), 32'd0);
        i_w_m_wr_rst_n = 1'b1;
        check("rst_tx_online", 32'(tx_online), 32'd0);

        // Register defaults and access
        rd(32'h5000_2000, 32'd12,   "dly_x_rst");
        rd(32'h5000_2004, 32'd32,   "dly_y_rst");
        rd(32'h5000_2008, 32'd6000, "dly_z_rst");
        rd(32'h5000_1004, 32'd0,    "l2f_stat_rst");
        wr(32'h5000_2000, 32'hC);
        rd(32'h5000_2000, 32'hC,    "dly_x_rw");
        wr(32'h5000_2004, 32'h1234_5678);
        rd(32'h5000_2004, 32'h1234_5678, "dly_y_rw");
        rd(32'h5000_9000, 32'd0,    "unmapped");

        r0 = resp_cnt;
        exp_q.push_back(32'h1234_5678);
        name_q.push_back("hold_read_data");
        @(posedge ms_wr_clk); #1;
        i_wr_addr = 32'h5000_2004; i_rden = 1'b1;
        repeat (3) @(posedge ms_wr_clk);
        #1 i_rden = 1'b0;
        repeat (3) @(posedge ms_wr_clk);
        #1;
        check("hold_single_resp", 32'(resp_cnt - r0), 32'd1);

        // Soft-reset pulse and link-up
        wr(32'h5000_3000, 32'd1);
        rd(32'h5000_3000, 32'd1,   "soft_rst_rb");
        rd(32'h5000_1010, 32'd0,   "linkup_held");
        wr(32'h5000_3000, 32'd0);
        repeat (13) @(posedge ms_wr_clk);
        rd(32'h5000_1010, 32'hF,   "linkup_up");
        check("tx_online", 32'(tx_online), 32'd1);
        check("rx_online", 32'(rx_online), 32'd1);

        // LFSR run, 256 beats both directions
        wr(32'h5000_1000, 32'hFF5);
        wr(32'h5000_1008, 32'hFF5);
        wait_done(1000, "lfsr_done_wait");
        rd(32'h5000_1004, 32'hB,   "l2f_stat_lfsr");
        rd(32'h5000_100C, 32'hB,   "f2l_stat_lfsr");
        rd(32'h5000_1000, 32'hFF5, "l2f_ctrl_rb");
        for (int k = 0; k < 8; k++) begin
            rd(32'h5000_4000 + 32'(4*k), l2f_first[k], $sformatf("l2f_txf_w%0d", k));
            rd(32'h5000_4100 + 32'(4*k), l2f_last[k],  $sformatf("l2f_txl_w%0d", k));
            rd(32'h5000_4200 + 32'(4*k), l2f_first[k], $sformatf("l2f_rxf_w%0d", k));
            rd(32'h5000_4300 + 32'(4*k), l2f_last[k],  $sformatf("l2f_rxl_w%0d", k));
        end
        rd(32'h5000_5000, f2l_first[0], "f2l_txf_w0");
        rd(32'h5000_5304, f2l_last[1],  "f2l_rxl_w1");
        rd(32'h5000_511C, f2l_last[7],  "f2l_txl_w7");

        // Error injection on one L2F beat
        wr(32'h5000_1000, 32'hFF5);
        wr(32'h5000_1008, 32'hFF5);
        repeat (50) @(posedge ms_wr_clk);
        @(negedge ms_wr_clk);
        corrupt = dut.u_l2f.rx_data ^ 256'd1;
        force dut.u_l2f.rx_data = corrupt;
        @(posedge ms_wr_clk); #1;
        release dut.u_l2f.rx_data;
        wait_done(1000, "err_done_wait");
        rd(32'h5000_1004, 32'hA, "l2f_stat_err");
        rd(32'h5000_100C, 32'hB, "f2l_stat_err");

        // Counter mode, 4 beats
        wr(32'h5000_1000, 32'h31);
        repeat (30) @(posedge ms_wr_clk);
        rd(32'h5000_1004, 32'hB,  "l2f_stat_cnt");
        rd(32'h5000_4100, 32'd24, "cnt_txl_w0");
        rd(32'h5000_4104, 32'd25, "cnt_txl_w1");
        rd(32'h5000_431C, 32'd31, "cnt_rxl_w7");
        rd(32'h5000_401C, 32'd7,  "cnt_txf_w7");

        // Abort mid-test, then restart
        wr(32'h5000_1000, 32'hFF5);
        repeat (20) @(posedge ms_wr_clk);
        #1;
        check("abort_valid_before", 32'(o_tb_axist_valid), 32'd1);
        wr(32'h5000_3000, 32'd1);
        repeat (2) @(posedge ms_wr_clk);
        #1;
        check("abort_valid_after", 32'(o_tb_axist_valid), 32'd0);
        rd(32'h5000_1004, 32'd0, "abort_l2f_stat");
        rd(32'h5000_100C, 32'd0, "abort_f2l_stat");
        wr(32'h5000_3000, 32'd0);
        repeat (15) @(posedge ms_wr_clk);
        wr(32'h5000_1000, 32'hFF5);
        repeat (300) @(posedge ms_wr_clk);
        rd(32'h5000_1004, 32'hB, "restart_l2f_stat");
        rd(32'h5000_4304, l2f_last[1], "restart_rxl_w1");
        #1;
        check("restart_test_done", 32'(test_done), 32'd0);

        repeat (5) @(posedge ms_wr_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
